// File: rtl/conv_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : conv_scheduler
// Description : Convolution control FSM that loads feature weights, then
//               raster-scans windows with a two-stage valid/ready pipeline.
// Revision    : 1.0
// ============================================================================
module conv_scheduler #(
    parameter int IMAGE_WIDTH  = 28,
    parameter int IMAGE_HEIGHT = 28,
    parameter int NUM_FEATURES = 10,
    parameter int KERNEL_SIZE  = 3,
    parameter int STRIDE       = 1
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 i_load_weights,
    input  logic                                 i_w_valid,
    input  logic [KERNEL_SIZE*KERNEL_SIZE-1:0]   i_w_data,
    output logic                                 o_w_ready,
    output logic [$clog2(NUM_FEATURES):0]        o_mem_waddr,
    output logic [KERNEL_SIZE*KERNEL_SIZE-1:0]   o_mem_wdata,
    output logic                                 o_mem_wr_n,
    input  logic                                 i_start,
    input  logic                                 i_abort,
    output logic                                 o_win_valid,
    output logic [$clog2(IMAGE_HEIGHT)-1:0]      o_win_row,
    output logic [$clog2(IMAGE_WIDTH)-1:0]       o_win_col,
    output logic                                 o_out_valid,
    output logic [$clog2(IMAGE_HEIGHT)-1:0]      o_out_row,
    output logic [$clog2(IMAGE_WIDTH)-1:0]       o_out_col,
    input  logic                                 i_out_ready,
    output logic                                 o_busy,
    output logic                                 o_weights_ok,
    output logic                                 o_done,
    output logic                                 o_err
);

    localparam int c_KK    = KERNEL_SIZE * KERNEL_SIZE;
    localparam int c_AW    = $clog2(NUM_FEATURES) + 1;
    localparam int c_RW    = $clog2(IMAGE_HEIGHT);
    localparam int c_CW    = $clog2(IMAGE_WIDTH);
    localparam int c_OUT_W = (IMAGE_WIDTH - KERNEL_SIZE) / STRIDE + 1;
    localparam int c_OUT_H = (IMAGE_HEIGHT - KERNEL_SIZE) / STRIDE + 1;

    localparam logic [2:0] c_IDLE  = 3'd0;
    localparam logic [2:0] c_LOADW = 3'd1;
    localparam logic [2:0] c_SCAN  = 3'd2;
    localparam logic [2:0] c_FLUSH = 3'd3;
    localparam logic [2:0] c_DONE  = 3'd4;

    logic [2:0]      r_state;
    logic [2:0]      w_next_state;
    logic [c_AW-1:0] r_beat_cnt;
    logic            r_mem_wr_n;
    logic [c_AW-1:0] r_mem_waddr;
    logic [c_KK-1:0] r_mem_wdata;
    logic            r_weights_ok;
    logic            r_err;
    logic            r_win_valid;
    logic [c_RW-1:0] r_win_row;
    logic [c_CW-1:0] r_win_col;
    logic [c_RW-1:0] r_pos_row;
    logic [c_CW-1:0] r_pos_col;
    logic            r_out_valid;
    logic [c_RW-1:0] r_out_row;
    logic [c_CW-1:0] r_out_col;

    logic w_beat_acc;
    logic w_last_write;
    logic w_enter_loadw;
    logic w_enter_scan;
    logic w_stall;
    logic w_issue;
    logic w_last_pos;

    assign w_enter_loadw = (r_state == c_IDLE) & i_load_weights & ~i_abort;
    assign w_enter_scan  = (r_state == c_IDLE) & ~i_load_weights & i_start & r_weights_ok & ~i_abort;
    assign w_beat_acc    = o_w_ready & i_w_valid & ~i_abort;
    assign w_last_write  = (r_state == c_LOADW) & ~r_mem_wr_n
                         & (r_mem_waddr == c_AW'(NUM_FEATURES - 1));
    assign w_stall       = r_out_valid & ~i_out_ready;
    assign w_issue       = r_win_valid & ~w_stall;
    assign w_last_pos    = (r_pos_row == c_RW'(c_OUT_H - 1)) & (r_pos_col == c_CW'(c_OUT_W - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        if (i_abort) begin
            w_next_state = c_IDLE;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (w_enter_loadw)     w_next_state = c_LOADW;
                    else if (w_enter_scan) w_next_state = c_SCAN;
                end
                c_LOADW: if (w_last_write)            w_next_state = c_IDLE;
                c_SCAN:  if (w_issue && w_last_pos)   w_next_state = c_FLUSH;
                c_FLUSH: if (r_out_valid && i_out_ready) w_next_state = c_DONE;
                c_DONE:  w_next_state = c_IDLE;
                default: w_next_state = c_IDLE;
            endcase
        end
    end

    always_comb begin
        o_busy    = 1'b0;
        o_w_ready = 1'b0;
        o_done    = 1'b0;
        case (r_state)
            c_LOADW: begin
                o_busy    = 1'b1;
                o_w_ready = (r_beat_cnt != c_AW'(NUM_FEATURES));
            end
            c_SCAN, c_FLUSH: o_busy = 1'b1;
            c_DONE:          o_done = 1'b1;
            default: ;
        endcase
    end

    // Each accepted beat becomes a one-cycle active-low write on the next cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_beat_cnt  <= '0;
            r_mem_wr_n  <= 1'b1;
            r_mem_waddr <= '0;
            r_mem_wdata <= '0;
        end else begin
            r_mem_wr_n <= ~w_beat_acc;
            if (w_enter_loadw) begin
                r_beat_cnt <= '0;
            end else if (w_beat_acc) begin
                r_beat_cnt  <= r_beat_cnt + c_AW'(1);
                r_mem_waddr <= r_beat_cnt;
                r_mem_wdata <= i_w_data;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_weights_ok <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_err <= (r_state == c_IDLE) & ~i_abort & ~i_load_weights & i_start & ~r_weights_ok;
            if (i_abort) begin
                if (r_state == c_LOADW) r_weights_ok <= 1'b0;
            end else if (w_enter_loadw) begin
                r_weights_ok <= 1'b0;
            end else if (w_last_write) begin
                r_weights_ok <= 1'b1;
            end
        end
    end

    // Window stage feeds the result stage; a stalled result freezes both.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_win_valid <= 1'b0;
            r_win_row   <= '0;
            r_win_col   <= '0;
            r_pos_row   <= '0;
            r_pos_col   <= '0;
            r_out_valid <= 1'b0;
            r_out_row   <= '0;
            r_out_col   <= '0;
        end else if (i_abort) begin
            r_win_valid <= 1'b0;
            r_out_valid <= 1'b0;
        end else if (w_enter_scan) begin
            r_win_valid <= 1'b1;
            r_win_row   <= '0;
            r_win_col   <= '0;
            r_pos_row   <= '0;
            r_pos_col   <= '0;
            r_out_valid <= 1'b0;
        end else if (!w_stall) begin
            r_out_valid <= r_win_valid;
            r_out_row   <= r_pos_row;
            r_out_col   <= r_pos_col;
            if (r_win_valid) begin
                if (w_last_pos) begin
                    r_win_valid <= 1'b0;
                end else if (r_pos_col == c_CW'(c_OUT_W - 1)) begin
                    r_pos_col <= '0;
                    r_win_col <= '0;
                    r_pos_row <= r_pos_row + c_RW'(1);
                    r_win_row <= r_win_row + c_RW'(STRIDE);
                end else begin
                    r_pos_col <= r_pos_col + c_CW'(1);
                    r_win_col <= r_win_col + c_CW'(STRIDE);
                end
            end
        end
    end

    assign o_mem_waddr  = r_mem_waddr;
    assign o_mem_wdata  = r_mem_wdata;
    assign o_mem_wr_n   = r_mem_wr_n;
    assign o_win_valid  = r_win_valid;
    assign o_win_row    = r_win_row;
    assign o_win_col    = r_win_col;
    assign o_out_valid  = r_out_valid;
    assign o_out_row    = r_out_row;
    assign o_out_col    = r_out_col;
    assign o_weights_ok = r_weights_ok;
    assign o_err        = r_err;

endmodule
`default_nettype wire

// File: tb/tb_conv_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_conv_scheduler
// Description : Self-checking bench for conv_scheduler (stride 1 and stride 2).
// Revision    : 1.0
// ============================================================================
module tb_conv_scheduler;

    localparam int KK    = 9;
    localparam int A_OUT = (28 - 3) / 1 + 1;
    localparam int B_OUT = (28 - 3) / 2 + 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n, load_weights, w_valid, start, abort, out_ready;
    logic [KK-1:0] w_data;

    logic a_w_ready, a_mem_wr_n, a_win_valid, a_out_valid, a_busy, a_weights_ok, a_done, a_err;
    logic [4:0] a_mem_waddr, a_win_row, a_win_col, a_out_row, a_out_col;
    logic [KK-1:0] a_mem_wdata;
    logic b_w_ready, b_mem_wr_n, b_win_valid, b_out_valid, b_busy, b_weights_ok, b_done, b_err;
    logic [4:0] b_mem_waddr, b_win_row, b_win_col, b_out_row, b_out_col;
    logic [KK-1:0] b_mem_wdata;

    int pass_cnt = 0;
    int total_cnt = 0;

    conv_scheduler dut_a (
        .clk(clk), .rst_n(rst_n), .i_load_weights(load_weights), .i_w_valid(w_valid),
        .i_w_data(w_data), .o_w_ready(a_w_ready), .o_mem_waddr(a_mem_waddr),
        .o_mem_wdata(a_mem_wdata), .o_mem_wr_n(a_mem_wr_n), .i_start(start), .i_abort(abort),
        .o_win_valid(a_win_valid), .o_win_row(a_win_row), .o_win_col(a_win_col),
        .o_out_valid(a_out_valid), .o_out_row(a_out_row), .o_out_col(a_out_col),
        .i_out_ready(out_ready), .o_busy(a_busy), .o_weights_ok(a_weights_ok),
        .o_done(a_done), .o_err(a_err)
    );

    conv_scheduler #(.STRIDE(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .i_load_weights(load_weights), .i_w_valid(w_valid),
        .i_w_data(w_data), .o_w_ready(b_w_ready), .o_mem_waddr(b_mem_waddr),
        .o_mem_wdata(b_mem_wdata), .o_mem_wr_n(b_mem_wr_n), .i_start(start), .i_abort(abort),
        .o_win_valid(b_win_valid), .o_win_row(b_win_row), .o_win_col(b_win_col),
        .o_out_valid(b_out_valid), .o_out_row(b_out_row), .o_out_col(b_out_col),
        .i_out_ready(out_ready), .o_busy(b_busy), .o_weights_ok(b_weights_ok),
        .o_done(b_done), .o_err(b_err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        total_cnt++;
        if ({a_w_ready, a_mem_wr_n, a_win_valid, a_out_valid, a_busy, a_weights_ok, a_done, a_err} !== 8'b0100_0000)
            $display("FAIL reset_flags_a: got %b expected 01000000",
                     {a_w_ready, a_mem_wr_n, a_win_valid, a_out_valid, a_busy, a_weights_ok, a_done, a_err});
        else pass_cnt++;
        total_cnt++;
        if ({b_w_ready, b_mem_wr_n, b_win_valid, b_out_valid, b_busy, b_weights_ok, b_done, b_err} !== 8'b0100_0000)
            $display("FAIL reset_flags_b: got %b expected 01000000",
                     {b_w_ready, b_mem_wr_n, b_win_valid, b_out_valid, b_busy, b_weights_ok, b_done, b_err});
        else pass_cnt++;
        total_cnt++;
        if ({a_mem_waddr, a_mem_wdata, a_win_row, a_win_col, a_out_row, a_out_col} !== 34'd0)
            $display("FAIL reset_data_a: got %h expected 0",
                     {a_mem_waddr, a_mem_wdata, a_win_row, a_win_col, a_out_row, a_out_col});
        else pass_cnt++;
        rst_n = 1'b1;
        tick();
        total_cnt++;
        if (a_busy !== 1'b0 || a_win_valid !== 1'b0)
            $display("FAIL reset_release: got busy=%b win_valid=%b expected 0 0", a_busy, a_win_valid);
        else pass_cnt++;
    endtask

    task automatic test_start_no_weights();
        start = 1'b1;
        tick();
        start = 1'b0;
        total_cnt++;
        if ({a_err, a_busy, a_win_valid} !== 3'b100)
            $display("FAIL err_pulse: got err/busy/win=%b expected 100", {a_err, a_busy, a_win_valid});
        else pass_cnt++;
        tick();
        total_cnt++;
        if ({a_err, a_busy, a_win_valid} !== 3'b000)
            $display("FAIL err_clear: got err/busy/win=%b expected 000", {a_err, a_busy, a_win_valid});
        else pass_cnt++;
    endtask

    task automatic test_load(input bit with_start);
        logic [KK-1:0] exp_data [10];
        int  sent = 0;
        int  wrc = 0;
        int  cyc = 0;
        bit  prev_acc = 1'b0;
        load_weights = 1'b1;
        start = with_start;
        tick();
        load_weights = 1'b0;
        start = 1'b0;
        total_cnt++;
        if ({a_busy, a_w_ready, a_weights_ok, a_err, a_win_valid} !== 5'b11000)
            $display("FAIL load_entry: got busy/ready/ok/err/win=%b expected 11000",
                     {a_busy, a_w_ready, a_weights_ok, a_err, a_win_valid});
        else pass_cnt++;
        while (!(sent == 10 && wrc == 10) && cyc < 400) begin
            total_cnt++;
            if (a_mem_wr_n !== !prev_acc)
                $display("FAIL load_wr_n: cycle %0d got %b expected %b", cyc, a_mem_wr_n, !prev_acc);
            else pass_cnt++;
            if (prev_acc) begin
                total_cnt++;
                if (a_mem_waddr !== 5'(wrc) || a_mem_wdata !== exp_data[wrc])
                    $display("FAIL load_write: got addr=%0d data=%h expected addr=%0d data=%h",
                             a_mem_waddr, a_mem_wdata, wrc, exp_data[wrc]);
                else pass_cnt++;
                wrc++;
            end
            if (sent < 10) begin
                total_cnt++;
                if (a_w_ready !== 1'b1)
                    $display("FAIL load_ready: beat %0d got w_ready=%b expected 1", sent, a_w_ready);
                else pass_cnt++;
            end
            w_valid  = (sent < 10) && ($urandom_range(0, 2) != 0);
            w_data   = KK'($urandom);
            prev_acc = w_valid;
            if (prev_acc) begin
                exp_data[sent] = w_data;
                sent++;
            end
            tick();
            cyc++;
        end
        w_valid = 1'b0;
        total_cnt++;
        if (cyc >= 400)
            $display("FAIL load_timeout: got %0d beats %0d writes expected 10 10", sent, wrc);
        else pass_cnt++;
        total_cnt++;
        if ({a_weights_ok, a_busy, a_mem_wr_n} !== 3'b101)
            $display("FAIL load_done: got ok/busy/wr_n=%b expected 101", {a_weights_ok, a_busy, a_mem_wr_n});
        else pass_cnt++;
    endtask

    task automatic test_scan(input int ready_pct);
        int er[$], ec[$], wr[$], wc[$];
        int cyc = 1, last_acc = -10, first_out = -1, n_res = 0, r, c;
        bit done_seen = 1'b0;
        for (int i = 0; i < A_OUT; i++)
            for (int j = 0; j < A_OUT; j++) begin
                er.push_back(i); ec.push_back(j);
                wr.push_back(i * 1); wc.push_back(j * 1);
            end
        out_ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        total_cnt++;
        if ({a_busy, a_win_valid, a_out_valid} !== 3'b110)
            $display("FAIL scan_entry: got busy/win/out=%b expected 110", {a_busy, a_win_valid, a_out_valid});
        else pass_cnt++;
        while (!done_seen && cyc < 4000) begin
            out_ready = ($urandom_range(0, 99) < ready_pct);
            if (a_done) begin
                done_seen = 1'b1;
                total_cnt++;
                if (er.size() != 0 || last_acc != cyc - 1)
                    $display("FAIL done_timing: got done at %0d with %0d left expected at %0d with 0 left",
                             cyc, er.size(), last_acc + 1);
                else pass_cnt++;
            end
            if (a_win_valid && !(a_out_valid && !out_ready)) begin
                total_cnt++;
                if (wr.size() == 0) begin
                    $display("FAIL win_extra: got window (%0d,%0d) expected none", a_win_row, a_win_col);
                end else begin
                    r = wr.pop_front();
                    c = wc.pop_front();
                    if (a_win_row !== 5'(r) || a_win_col !== 5'(c))
                        $display("FAIL win_coord: got (%0d,%0d) expected (%0d,%0d)", a_win_row, a_win_col, r, c);
                    else pass_cnt++;
                end
            end
            if (a_out_valid) begin
                if (first_out < 0) begin
                    first_out = cyc;
                    total_cnt++;
                    if (cyc != 2) $display("FAIL first_out_latency: got %0d expected 2", cyc);
                    else pass_cnt++;
                end
                if (out_ready) begin
                    total_cnt++;
                    if (er.size() == 0) begin
                        $display("FAIL out_extra: got (%0d,%0d) expected none", a_out_row, a_out_col);
                    end else begin
                        r = er.pop_front();
                        c = ec.pop_front();
                        if (a_out_row !== 5'(r) || a_out_col !== 5'(c))
                            $display("FAIL out_coord: got (%0d,%0d) expected (%0d,%0d)", a_out_row, a_out_col, r, c);
                        else pass_cnt++;
                    end
                    last_acc = cyc;
                    n_res++;
                end
            end
            tick();
            cyc++;
        end
        out_ready = 1'b1;
        total_cnt++;
        if (!done_seen || n_res != A_OUT * A_OUT)
            $display("FAIL scan_count: got %0d results done=%b expected %0d done=1", n_res, done_seen, A_OUT * A_OUT);
        else pass_cnt++;
        total_cnt++;
        if ({a_done, a_busy, a_weights_ok} !== 3'b001)
            $display("FAIL done_pulse: got done/busy/ok=%b expected 001", {a_done, a_busy, a_weights_ok});
        else pass_cnt++;
    endtask

    task automatic test_stall();
        int cyc = 0;
        out_ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        while (!(a_out_valid && a_out_row == 5'd0 && a_out_col == 5'd3) && cyc < 50) begin
            tick();
            cyc++;
        end
        total_cnt++;
        if (cyc >= 50) $display("FAIL stall_reach: got no (0,3) within %0d cycles expected (0,3)", cyc);
        else pass_cnt++;
        for (int i = 0; i < 5; i++) begin
            out_ready = 1'b0;
            tick();
            total_cnt++;
            if (a_out_valid !== 1'b1 || a_out_row !== 5'd0 || a_out_col !== 5'd3)
                $display("FAIL stall_out: got v=%b (%0d,%0d) expected v=1 (0,3)", a_out_valid, a_out_row, a_out_col);
            else pass_cnt++;
            total_cnt++;
            if (a_win_valid !== 1'b1 || a_win_row !== 5'd0 || a_win_col !== 5'd4)
                $display("FAIL stall_win: got v=%b (%0d,%0d) expected v=1 (0,4)", a_win_valid, a_win_row, a_win_col);
            else pass_cnt++;
        end
        out_ready = 1'b1;
        tick();
        total_cnt++;
        if (a_out_row !== 5'd0 || a_out_col !== 5'd4 || a_win_col !== 5'd5)
            $display("FAIL stall_resume: got out=(%0d,%0d) win_col=%0d expected out=(0,4) win_col=5",
                     a_out_row, a_out_col, a_win_col);
        else pass_cnt++;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        total_cnt++;
        if ({a_win_valid, a_out_valid, a_busy, a_done, a_weights_ok, a_mem_wr_n} !== 6'b000011)
            $display("FAIL stall_abort: got win/out/busy/done/ok/wr_n=%b expected 000011",
                     {a_win_valid, a_out_valid, a_busy, a_done, a_weights_ok, a_mem_wr_n});
        else pass_cnt++;
    endtask

    task automatic test_stride_abort();
        int er[$], ec[$], wr[$], wc[$];
        int cyc = 1, n = 0, r, c;
        for (int i = 0; i < B_OUT; i++)
            for (int j = 0; j < B_OUT; j++) begin
                er.push_back(i); ec.push_back(j);
                wr.push_back(i * 2); wc.push_back(j * 2);
            end
        out_ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        while (n < 50 && cyc < 500) begin
            if (b_win_valid) begin
                r = wr.pop_front();
                c = wc.pop_front();
                total_cnt++;
                if (b_win_row !== 5'(r) || b_win_col !== 5'(c))
                    $display("FAIL s2_win: got (%0d,%0d) expected (%0d,%0d)", b_win_row, b_win_col, r, c);
                else pass_cnt++;
            end
            if (b_out_valid) begin
                r = er.pop_front();
                c = ec.pop_front();
                total_cnt++;
                if (b_out_row !== 5'(r) || b_out_col !== 5'(c))
                    $display("FAIL s2_out: got (%0d,%0d) expected (%0d,%0d)", b_out_row, b_out_col, r, c);
                else pass_cnt++;
                n++;
            end
            tick();
            cyc++;
        end
        total_cnt++;
        if (b_out_valid !== 1'b1 || b_out_row !== 5'(er[0]) || b_out_col !== 5'(ec[0]))
            $display("FAIL s2_result50: got v=%b (%0d,%0d) expected v=1 (%0d,%0d)",
                     b_out_valid, b_out_row, b_out_col, er[0], ec[0]);
        else pass_cnt++;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        total_cnt++;
        if ({b_win_valid, b_out_valid, b_busy, b_done, b_weights_ok, b_mem_wr_n} !== 6'b000011)
            $display("FAIL s2_abort: got win/out/busy/done/ok/wr_n=%b expected 000011",
                     {b_win_valid, b_out_valid, b_busy, b_done, b_weights_ok, b_mem_wr_n});
        else pass_cnt++;
        for (int i = 0; i < 3; i++) begin
            tick();
            total_cnt++;
            if (b_done !== 1'b0 || b_out_valid !== 1'b0)
                $display("FAIL s2_no_done: got done=%b out_valid=%b expected 0 0", b_done, b_out_valid);
            else pass_cnt++;
        end
    endtask

    task automatic test_reset_midscan();
        out_ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (20) tick();
        rst_n = 1'b0;
        #2;
        total_cnt++;
        if ({a_w_ready, a_mem_wr_n, a_win_valid, a_out_valid, a_busy, a_weights_ok, a_done, a_err} !== 8'b0100_0000)
            $display("FAIL midrst_flags: got %b expected 01000000",
                     {a_w_ready, a_mem_wr_n, a_win_valid, a_out_valid, a_busy, a_weights_ok, a_done, a_err});
        else pass_cnt++;
        total_cnt++;
        if ({a_mem_waddr, a_mem_wdata, a_win_row, a_win_col, a_out_row, a_out_col} !== 34'd0)
            $display("FAIL midrst_data: got %h expected 0",
                     {a_mem_waddr, a_mem_wdata, a_win_row, a_win_col, a_out_row, a_out_col});
        else pass_cnt++;
        total_cnt++;
        if ({b_win_valid, b_out_valid, b_weights_ok, b_mem_wr_n} !== 4'b0001)
            $display("FAIL midrst_b: got win/out/ok/wr_n=%b expected 0001",
                     {b_win_valid, b_out_valid, b_weights_ok, b_mem_wr_n});
        else pass_cnt++;
        tick();
        rst_n = 1'b1;
        tick();
        total_cnt++;
        if ({a_busy, a_win_valid, a_weights_ok} !== 3'b000)
            $display("FAIL midrst_idle: got busy/win/ok=%b expected 000", {a_busy, a_win_valid, a_weights_ok});
        else pass_cnt++;
        start = 1'b1;
        tick();
        start = 1'b0;
        total_cnt++;
        if ({a_err, a_busy} !== 2'b10)
            $display("FAIL midrst_err: got err/busy=%b expected 10", {a_err, a_busy});
        else pass_cnt++;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n        = 1'b0;
        load_weights = 1'b0;
        w_valid      = 1'b0;
        w_data       = '0;
        start        = 1'b0;
        abort        = 1'b0;
        out_ready    = 1'b1;
        test_reset();
        test_start_no_weights();
        test_load(1'b0);
        test_scan(100);
        test_load(1'b1);
        test_scan(60);
        test_stall();
        test_stride_abort();
        test_reset_midscan();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
`default_nettype wire
